// File: rtl/signed_seq_divider.sv
// Signed sequential restoring divider: one quotient bit per cycle, sign fix-up, registered results.
// Optional macro DIV_ZERO_FAST_EN: short-circuit divide-by-zero and raise div_zero.
module signed_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q, dvsr_q;
  logic             q_neg_q, r_neg_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  logic             accept, dvsr_zero, fast_zero;
  logic [WIDTH-1:0] dvnd_mag, dvsr_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             fits;

  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign dvsr_zero = (divisor == '0);
  // Magnitudes wrap modulo 2^WIDTH, so MIN_INT keeps its bit pattern and divides as unsigned.
  assign dvnd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvsr_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, dvsr_q});
  assign diff    = shifted - {1'b0, dvsr_q};

`ifdef DIV_ZERO_FAST_EN
  logic dz_q;
  assign fast_zero = dvsr_zero;
  assign div_zero  = dz_q && (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dz_q <= 1'b0;
    else if (accept) dz_q <= dvsr_zero;
  end
`else
  assign fast_zero = 1'b0;
  assign div_zero  = 1'b0;
`endif

  assign busy      = (state_q == ITER) || (state_q == FIX);
  assign done      = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start)                 state_d = fast_zero ? FIX : ITER;
        else if (state_q == DONE)  state_d = IDLE;
      end
      ITER:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      dvsr_q <= dvsr_mag;
      if (fast_zero) begin
        // Preload FIX with the divide-by-zero answer; no sign fix-up applies.
        rem_q   <= {1'b0, dividend};
        quo_q   <= '1;
        q_neg_q <= 1'b0;
        r_neg_q <= 1'b0;
      end else begin
        rem_q   <= '0;
        quo_q   <= dvnd_mag;
        // A zero divisor yields an all-ones quotient; keep it unnegated.
        q_neg_q <= (dividend[WIDTH-1] ^ divisor[WIDTH-1]) && !dvsr_zero;
        r_neg_q <= dividend[WIDTH-1];
      end
    end else if (state_q == ITER) begin
      cnt_q <= cnt_q + CW'(1);
      quo_q <= {quo_q[WIDTH-2:0], fits};
      rem_q <= fits ? diff : shifted;
    end else if (state_q == FIX) begin
      quotient_q  <= q_neg_q ? -quo_q : quo_q;
      remainder_q <= r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed self-checking bench for signed_seq_divider (WIDTH=32), honours DIV_ZERO_FAST_EN.
module tb_signed_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  signed_seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 2;
  localparam bit ZERO_FLAG = 1'b1;
`else
  localparam int ZERO_LAT = W + 2;
  localparam bit ZERO_FLAG = 1'b0;
`endif

  // Drive operands before a rising edge; that edge is edge 0.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the edge number at which done is seen high (-1 on timeout).
  task automatic wait_done(output int edge_n, output logic busy1, output logic [W-1:0] q1);
    edge_n = -1;
    busy1  = 1'b0;
    q1     = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) begin busy1 = busy; q1 = quotient; end
      if (done) begin edge_n = k; break; end
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({busy, done, div_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b dz=%b q=%h r=%h, want all 0",
               busy, done, div_zero, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int e; logic b1; logic [W-1:0] q1;
    launch(32'd100, 32'd7);
    wait_done(e, b1, q1);
    n_cmp++;
    if (e !== W + 2) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", e, W + 2); end
    n_cmp++;
    if (b1 !== 1'b1) begin n_bad++; $display("FAIL basic_busy_iter: got %b want 1", b1); end
    n_cmp++;
    if (busy !== 1'b0 || div_zero !== 1'b0) begin
      n_bad++; $display("FAIL basic_flags_done: got busy=%b dz=%b want 0 0", busy, div_zero);
    end
    n_cmp++;
    if (quotient !== 32'd14 || remainder !== 32'd2) begin
      n_bad++; $display("FAIL basic_result: got q=%h r=%h want q=0000000e r=00000002", quotient, remainder);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || quotient !== 32'd14) begin
      n_bad++; $display("FAIL basic_done_pulse: got done=%b q=%h want 0 0000000e", done, quotient);
    end
  endtask

  task automatic test_signs;
    int e; logic b1; logic [W-1:0] q1;
    launch(-32'sd100, 32'd7);
    wait_done(e, b1, q1);
    n_cmp++;
    if (q1 !== 32'd14) begin n_bad++; $display("FAIL result_hold: got q=%h want 0000000e", q1); end
    n_cmp++;
    if (e !== W + 2 || quotient !== 32'hFFFF_FFF2 || remainder !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL neg_dividend: got edge=%0d q=%h r=%h want 34 fffffff2 fffffffe", e, quotient, remainder);
    end
    launch(32'd100, -32'sd7);
    wait_done(e, b1, q1);
    n_cmp++;
    if (quotient !== 32'hFFFF_FFF2 || remainder !== 32'd2) begin
      n_bad++; $display("FAIL neg_divisor: got q=%h r=%h want fffffff2 00000002", quotient, remainder);
    end
    launch(-32'sd100, -32'sd7);
    wait_done(e, b1, q1);
    n_cmp++;
    if (quotient !== 32'd14 || remainder !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL both_neg: got q=%h r=%h want 0000000e fffffffe", quotient, remainder);
    end
    launch(32'd7, 32'd100);
    wait_done(e, b1, q1);
    n_cmp++;
    if (quotient !== 32'd0 || remainder !== 32'd7) begin
      n_bad++; $display("FAIL small_dividend: got q=%h r=%h want 00000000 00000007", quotient, remainder);
    end
  endtask

  task automatic test_min_int;
    int e; logic b1; logic [W-1:0] q1;
    launch(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(e, b1, q1);
    n_cmp++;
    if (quotient !== 32'h8000_0000 || remainder !== 32'd0 || div_zero !== 1'b0) begin
      n_bad++; $display("FAIL min_int_div_m1: got q=%h r=%h dz=%b want 80000000 00000000 0", quotient, remainder, div_zero);
    end
  endtask

  task automatic test_div_zero;
    int e; logic b1; logic [W-1:0] q1;
    launch(-32'sd5, 32'd0);
    wait_done(e, b1, q1);
    n_cmp++;
    if (e !== ZERO_LAT) begin n_bad++; $display("FAIL dz_latency: got %0d want %0d", e, ZERO_LAT); end
    n_cmp++;
    if (b1 !== 1'b1) begin n_bad++; $display("FAIL dz_busy: got %b want 1", b1); end
    n_cmp++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'hFFFF_FFFB || div_zero !== ZERO_FLAG) begin
      n_bad++; $display("FAIL dz_neg: got q=%h r=%h dz=%b want ffffffff fffffffb %b", quotient, remainder, div_zero, ZERO_FLAG);
    end
    launch(32'd12, 32'd0);
    wait_done(e, b1, q1);
    n_cmp++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd12 || div_zero !== ZERO_FLAG) begin
      n_bad++; $display("FAIL dz_pos: got q=%h r=%h dz=%b want ffffffff 0000000c %b", quotient, remainder, div_zero, ZERO_FLAG);
    end
  endtask

  task automatic test_back_to_back;
    int e; logic b1; logic [W-1:0] q1;
    e = -1;
    launch(32'd100, 32'd7);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 9)  begin start = 1'b1; dividend = 32'd55; divisor = 32'd5; end
      if (k == 10) start = 1'b0;
      if (done) begin e = k; break; end
    end
    n_cmp++;
    if (e !== W + 2 || quotient !== 32'd14 || remainder !== 32'd2) begin
      n_bad++; $display("FAIL ignore_start: got edge=%0d q=%h r=%h want 34 0000000e 00000002", e, quotient, remainder);
    end
    launch(-32'sd9, 32'd2);
    wait_done(e, b1, q1);
    n_cmp++;
    if (e !== W + 2 || quotient !== 32'hFFFF_FFFC || remainder !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL back_to_back: got edge=%0d q=%h r=%h want 34 fffffffc ffffffff", e, quotient, remainder);
    end
  endtask

  task automatic test_mid_reset;
    int e; logic b1; logic [W-1:0] q1; bit saw_done;
    saw_done = 1'b0;
    launch(32'd1000, 32'd7);
    for (int k = 1; k < 20; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, div_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got busy=%b done=%b dz=%b q=%h r=%h want all 0",
                        busy, done, div_zero, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin n_bad++; $display("FAIL mid_reset_abandon: got activity after reset want none"); end
    launch(32'd9, 32'd3);
    wait_done(e, b1, q1);
    n_cmp++;
    if (e !== W + 2 || quotient !== 32'd3 || remainder !== 32'd0) begin
      n_bad++; $display("FAIL after_reset: got edge=%0d q=%h r=%h want 34 00000003 00000000", e, quotient, remainder);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signs;
    test_min_int;
    test_div_zero;
    test_back_to_back;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
